// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset release sequencer.
package reset_seq_pkg;

    localparam int SEQ_MAX_STAGES = 16;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } seq_state_e;

    // Width of the shared counter: wide enough to hold the largest compare value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq.sv
// Staged reset release sequencer: holds all stage resets asserted for a minimum
// time, then releases them one by one, waiting for each stage's ready acknowledge.
//
// state    | meaning
// ---------+----------------------------------------------------------
// HOLD     | all outputs asserted, counting the minimum hold time
// WAIT_ACK | stage stg released, waiting for stage_ready_i[stg]
// GAP      | ack seen, counting the gap before releasing stage stg
// DONE     | all stages released and acknowledged
// ERROR    | acknowledge timed out; released stages stay released
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  synced_i,
    input  logic                  sw_rst_req_i,
    input  logic [NUM_STAGES-1:0] stage_ready_i,
    output logic [NUM_STAGES-1:0] rstn_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_LAST  = (STAGE_GAP > 0) ? CW'(STAGE_GAP - 1) : '0;
    localparam logic [CW-1:0] TO_LAST   = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
    localparam logic [SW-1:0] LAST_STG  = SW'(NUM_STAGES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > SEQ_MAX_STAGES) begin : g_bad_stages
        $error("reset_seq: NUM_STAGES out of range");
    end

    seq_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         stg_q, stg_d;
    logic [NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;

    logic                  re_req;
    logic [NUM_STAGES-1:0] rstn_next;
    logic [CW-1:0]         cnt_inc;

    // Re-request detection, next-release mask (outputs form a thermometer) and saturating count.
    always_comb begin
        re_req    = !synced_i || sw_rst_req_i;
        rstn_next = (rstn_q << 1) | NUM_STAGES'(1);
        cnt_inc   = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // Next-state and next-output computation; re-request overrides the FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stg_d     = stg_q;
        rstn_d    = rstn_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        if (re_req) begin
            state_d   = HOLD;
            cnt_d     = '0;
            stg_d     = '0;
            rstn_d    = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rstn_d  = rstn_next;
                        cnt_d   = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_ACK: begin
                    if (stage_ready_i[stg_q]) begin
                        cnt_d = '0;
                        if (stg_q == LAST_STG) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            rstn_d = rstn_next;
                            stg_d  = stg_q + 1'b1;
                        end else begin
                            stg_d   = stg_q + 1'b1;
                            state_d = GAP;
                        end
                    end else if (ACK_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ERROR;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rstn_d  = rstn_next;
                        cnt_d   = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stg_d   = '0;
                    rstn_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            stg_q     <= '0;
            rstn_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stg_q     <= stg_d;
            rstn_q    <= rstn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign rstn_o    = rstn_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: main instance (3 stages, hold 4, gap 2, timeout 8)
// and a zero-gap, no-timeout instance sharing the reset controls.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       synced = 1'b1;
    logic       sw_req = 1'b0;
    logic [2:0] ready = 3'b000;
    logic [2:0] ready0 = 3'b000;

    logic [2:0] rstn_o, rstn0_o;
    logic       busy, done, tmo;
    logic       busy0, done0, tmo0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_seq #(.NUM_STAGES(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .ACK_TIMEOUT(8)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .synced_i(synced), .sw_rst_req_i(sw_req),
        .stage_ready_i(ready), .rstn_o(rstn_o), .busy_o(busy), .done_o(done),
        .timeout_o(tmo)
    );

    reset_seq #(.NUM_STAGES(3), .HOLD_CYCLES(4), .STAGE_GAP(0), .ACK_TIMEOUT(0)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn), .synced_i(synced), .sw_rst_req_i(sw_req),
        .stage_ready_i(ready0), .rstn_o(rstn0_o), .busy_o(busy0), .done_o(done0),
        .timeout_o(tmo0)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        step(2);
        chk("rst_rstn", 32'(rstn_o), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);

        // basic sequence with hold timing
        rstn = 1'b1;
        step(3);
        chk("hold_e2", 32'(rstn_o), 32'h0);
        step(1);
        chk("hold_e3", 32'(rstn_o), 32'h0);
        step(1);
        chk("hold_e4", 32'(rstn_o), 32'h1);
        chk("hold_busy", 32'(busy), 32'h1);
        ready = 3'b001;
        step(2);
        chk("gap0_mid", 32'(rstn_o), 32'h1);
        step(1);
        chk("rel1", 32'(rstn_o), 32'h3);
        ready = 3'b011;
        step(2);
        chk("gap1_mid", 32'(rstn_o), 32'h3);
        step(1);
        chk("rel2", 32'(rstn_o), 32'h7);
        chk("rel2_done", 32'(done), 32'h0);
        ready = 3'b111;
        step(1);
        chk("done", 32'(done), 32'h1);
        chk("done_busy", 32'(busy), 32'h0);
        ready = 3'b000;
        step(2);
        chk("done_sticky", 32'(done), 32'h1);
        chk("done_rstn", 32'(rstn_o), 32'h7);

        // timeout on stage 1
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        chk("swreq_rstn", 32'(rstn_o), 32'h0);
        chk("swreq_done", 32'(done), 32'h0);
        chk("swreq_busy", 32'(busy), 32'h1);
        step(5);
        chk("to_rel0", 32'(rstn_o), 32'h1);
        ready = 3'b001;
        step(1);
        ready = 3'b000;
        step(2);
        chk("to_rel1", 32'(rstn_o), 32'h3);
        step(7);
        chk("to_before", 32'(tmo), 32'h0);
        step(1);
        chk("to_flag", 32'(tmo), 32'h1);
        chk("to_rstn", 32'(rstn_o), 32'h3);
        chk("to_done", 32'(done), 32'h0);
        chk("to_busy", 32'(busy), 32'h0);
        chk("nogap_rstn_wait", 32'(rstn0_o), 32'h1);
        chk("nogap_no_tmo", 32'(tmo0), 32'h0);
        step(3);
        chk("to_stays", 32'(tmo), 32'h1);

        // synced_i low for 10 cycles
        synced = 1'b0;
        step(1);
        chk("sync_tmo_clr", 32'(tmo), 32'h0);
        chk("sync_rstn", 32'(rstn_o), 32'h0);
        step(9);
        chk("sync_hold", 32'(rstn_o), 32'h0);
        synced = 1'b1;
        step(4);
        chk("sync_e3", 32'(rstn_o), 32'h0);
        step(1);
        chk("sync_e4", 32'(rstn_o), 32'h1);

        // sw request during GAP after stage 0
        ready = 3'b001;
        step(1);
        ready = 3'b000;
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        chk("gapreq_rstn", 32'(rstn_o), 32'h0);
        chk("gapreq_tmo", 32'(tmo), 32'h0);
        step(4);
        chk("gapreq_e3", 32'(rstn_o), 32'h0);
        step(1);
        chk("gapreq_e4", 32'(rstn_o), 32'h1);

        // ack and request on the same edge, then acks pre-asserted through HOLD
        ready = 3'b111;
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        chk("simul_rstn", 32'(rstn_o), 32'h0);
        step(4);
        chk("pre_e3", 32'(rstn_o), 32'h0);
        step(1);
        chk("pre_rel0", 32'(rstn_o), 32'h1);
        step(2);
        chk("pre_gap0", 32'(rstn_o), 32'h1);
        step(1);
        chk("pre_rel1", 32'(rstn_o), 32'h3);
        step(2);
        chk("pre_gap1", 32'(rstn_o), 32'h3);
        step(1);
        chk("pre_rel2", 32'(rstn_o), 32'h7);
        step(1);
        chk("pre_done", 32'(done), 32'h1);

        // zero-gap instance with acks tied high
        sw_req = 1'b1;
        step(1);
        sw_req = 1'b0;
        ready0 = 3'b111;
        chk("ng_rstn0", 32'(rstn0_o), 32'h0);
        step(4);
        chk("ng_e3", 32'(rstn0_o), 32'h0);
        step(1);
        chk("ng_001", 32'(rstn0_o), 32'h1);
        step(1);
        chk("ng_011", 32'(rstn0_o), 32'h3);
        step(1);
        chk("ng_111", 32'(rstn0_o), 32'h7);
        chk("ng_not_done", 32'(done0), 32'h0);
        step(1);
        chk("ng_done", 32'(done0), 32'h1);
        chk("ng_tmo", 32'(tmo0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
